// File: rtl/mem_stream_reader.sv
// mem_stream_reader: reads a burst of consecutive words from a synchronous-read
// memory port and presents them as a ready/valid stream through a 2-entry
// output buffer. The buffer absorbs the one-cycle memory read latency so the
// stream runs at full rate when the sink never stalls.
module mem_stream_reader #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW:0]      length,
  output logic [AW-1:0]    mem_address,
  input  logic [WIDTH-1:0] mem_q,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  // Address increment that wraps at DEPTH even when DEPTH is not a power of 2.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  logic [1:0]       state;
  logic [AW:0]      remaining;
  // vld_p1: a read was issued at the previous edge, so mem_q holds its word now
  logic             vld_p1;
  logic [1:0]       occ;
  logic             rd_ptr;
  logic             wr_ptr;
  logic [WIDTH-1:0] fifo_p2 [0:1];

  logic       xfer;
  logic       issue;
  logic [1:0] pend;
  logic [1:0] occ_next;

  // Issue/handshake decisions. The occupancy+in-flight bound guarantees an
  // in-flight word always finds a free buffer slot.
  always_comb begin
    xfer     = out_valid & out_ready;
    pend     = occ + {1'b0, vld_p1};
    issue    = (state == READ) && (remaining != '0) && ((pend <= 2'd1) || xfer);
    occ_next = occ + {1'b0, vld_p1} - {1'b0, xfer};
  end

  // ---- stage p0: burst control, address generation and read issue ----
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state       <= IDLE;
      mem_address <= '0;
      remaining   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      vld_p1      <= 1'b0;
      occ         <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              mem_address <= base_addr;
              remaining   <= length;
              busy        <= 1'b1;
              state       <= READ;
            end else begin
              done <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue) begin
            mem_address <= next_addr(mem_address);
            remaining   <= remaining - (AW+1)'(1);
            if (remaining == (AW+1)'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Final transfer: last buffered word leaves and nothing is in flight.
          if (xfer && (occ == 2'd1) && !vld_p1) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      vld_p1 <= issue;
      occ    <= occ_next;
      if (vld_p1) wr_ptr <= ~wr_ptr;
      if (xfer)   rd_ptr <= ~rd_ptr;
    end
  end

  // ---- stage p2: capture returning read data into the output buffer ----
  always_ff @(posedge clock) begin
    if (vld_p1) fifo_p2[wr_ptr] <= mem_q;
  end

  // Stream outputs; data is forced to zero whenever no word is held.
  always_comb begin
    out_valid = (occ != 2'd0);
    out_data  = out_valid ? fifo_p2[rd_ptr] : '0;
  end

endmodule
